alu_exec_stage: RTL and testbench

Registered execute stage directly upstream of the accumulator. It accepts one decoded operation per handshake, combines the current accumulator value with an operand, and drives the accumulator's write data and write enable. Most operations complete in one cycle. MUL is an 8-step iterative shift-add that stalls the issue handshake while it runs.

---
 rtl/alu_exec_stage_pkg.sv | 46 ++++
 rtl/alu_exec_stage_mul8.sv | 54 +++++
 rtl/alu_exec_stage.sv | 142 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_stage_pkg.sv
// Shared opcode, FSM state and ALU result types for the accumulator execute stage.
// The decode stage imports the same opcode enum so encodings cannot drift.
package alu_exec_stage_pkg;

    localparam int DATA_W    = 8;
    localparam int MUL_STEPS = 8;

    typedef enum logic [3:0] {
        OP_LD  = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_AND = 4'h3,
        OP_OR  = 4'h4,
        OP_XOR = 4'h5,
        OP_NOT = 4'h6,
        OP_GT  = 4'h7,
        OP_GE  = 4'h8,
        OP_EQ  = 4'h9,
        OP_NE  = 4'hA,
        OP_LE  = 4'hB,
        OP_LT  = 4'hC,
        OP_MUL = 4'hD,
        OP_SHL = 4'hE,
        OP_NOP = 4'hF
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Result of one single-cycle operation before it is registered.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              carry;
        logic              carry_upd;
        logic              wr;
    } alu_res_t;

    // Compare results are presented as a byte holding 0 or 1.
    function automatic logic [DATA_W-1:0] flag_byte(input logic t);
        return {{(DATA_W-1){1'b0}}, t};
    endfunction

endpackage

// File: rtl/alu_exec_stage_mul8.sv
// Iterative 8x8 unsigned shift-add multiplier, one partial product per clock.
// start loads the operands; done pulses for one cycle once prod is final.
module alu_mul8
    import alu_exec_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] prod,
    output logic        done
);

    logic [15:0] mcand;
    logic [7:0]  mplier;
    logic [15:0] acc;
    logic [2:0]  cnt;
    logic        run;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            run    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand  <= {8'h00, a};
                mplier <= b;
                acc    <= '0;
                cnt    <= '0;
                run    <= 1'b1;
            end else if (run) begin
                // Step cnt consumes multiplier bit cnt, held in mplier[0].
                if (mplier[0])
                    acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 3'd1;
                if (cnt == 3'(MUL_STEPS - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign prod = acc;

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage feeding the accumulator: single-cycle ALU ops are
// written on the accept edge, MUL is sequenced through alu_mul8 and stalls issue.
module alu_exec_stage
    import alu_exec_stage_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       op_valid,
    output logic       op_ready,
    input  logic [3:0] op_code,
    input  logic [7:0] op_a,
    input  logic [7:0] op_b,
    output logic [7:0] acc_wr_data,
    output logic       acc_wr_en,
    output logic       cflag,
    output logic       busy
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    op_e         op;
    logic        accept;
    logic        mul_start;
    logic [15:0] mul_prod;
    logic        mul_done;
    alu_res_t    res;
    logic [8:0]  ext9;

    assign op        = op_e'(op_code);
    assign op_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = op_valid && op_ready;
    assign mul_start = accept && (op == OP_MUL);

    alu_mul8 u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .prod    (mul_prod),
        .done    (mul_done)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // MUL occupies eight step cycles, then one DONE cycle while the product settles out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mul_start) begin
                    state_d = ST_MUL;
                    cnt_d   = '0;
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(MUL_STEPS - 1))
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        res.data      = 8'h00;
        res.carry     = cflag;
        res.carry_upd = 1'b0;
        res.wr        = 1'b1;
        ext9          = 9'h000;
        case (op)
            OP_LD:  res.data = op_b;
            OP_ADD: begin
                ext9          = {1'b0, op_a} + {1'b0, op_b};
                res.data      = ext9[7:0];
                res.carry     = ext9[8];
                res.carry_upd = 1'b1;
            end
            OP_SUB: begin
                // Bit 8 of the widened difference is the borrow.
                ext9          = {1'b0, op_a} - {1'b0, op_b};
                res.data      = ext9[7:0];
                res.carry     = ext9[8];
                res.carry_upd = 1'b1;
            end
            OP_AND: res.data = op_a & op_b;
            OP_OR:  res.data = op_a | op_b;
            OP_XOR: res.data = op_a ^ op_b;
            OP_NOT: res.data = ~op_a;
            OP_GT:  res.data = flag_byte(op_a >  op_b);
            OP_GE:  res.data = flag_byte(op_a >= op_b);
            OP_EQ:  res.data = flag_byte(op_a == op_b);
            OP_NE:  res.data = flag_byte(op_a != op_b);
            OP_LE:  res.data = flag_byte(op_a <= op_b);
            OP_LT:  res.data = flag_byte(op_a <  op_b);
            OP_SHL: begin
                // Bit 8 of the widened shift is the last bit out; zero for a shift of 0.
                ext9          = {1'b0, op_a} << op_b[2:0];
                res.data      = ext9[7:0];
                res.carry     = ext9[8];
                res.carry_upd = 1'b1;
            end
            OP_MUL: res.wr = 1'b0;
            OP_NOP: res.wr = 1'b0;
            default: res.wr = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_wr_en   <= 1'b0;
            acc_wr_data <= 8'h00;
            cflag       <= 1'b0;
        end else begin
            acc_wr_en <= 1'b0;
            if (state_q == ST_DONE) begin
                if (mul_done) begin
                    acc_wr_en   <= 1'b1;
                    acc_wr_data <= mul_prod[7:0];
                    cflag       <= |mul_prod[15:8];
                end
            end else if (accept && res.wr) begin
                acc_wr_en   <= 1'b1;
                acc_wr_data <= res.data;
                if (res.carry_upd)
                    cflag <= res.carry;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: the driver pushes expected writes from an
// arithmetic reference model, a negedge monitor pops and compares each strobe.
module tb_alu_exec_stage;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       op_valid = 1'b0;
    logic       op_ready;
    logic [3:0] op_code = 4'h0;
    logic [7:0] op_a = 8'h00;
    logic [7:0] op_b = 8'h00;
    logic [7:0] acc_wr_data;
    logic       acc_wr_en;
    logic       cflag;
    logic       busy;

    alu_exec_stage dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_code     (op_code),
        .op_a        (op_a),
        .op_b        (op_b),
        .acc_wr_data (acc_wr_data),
        .acc_wr_en   (acc_wr_en),
        .cflag       (cflag),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int data;
        int c;
        int due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    bit   model_c = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: each opcode's effect in plain integer arithmetic.
    function automatic void model(input int op, input int a, input int b, input bit cin,
                                  output bit wr, output int d, output bit c);
        int s;
        wr = 1'b1;
        c  = cin;
        d  = 0;
        s  = b % 8;
        case (op)
            0:  d = b;
            1:  begin d = (a + b) % 256; c = (a + b) > 255; end
            2:  begin d = (a - b + 256) % 256; c = a < b; end
            3:  d = a & b;
            4:  d = a | b;
            5:  d = a ^ b;
            6:  d = 255 - a;
            7:  d = (a >  b) ? 1 : 0;
            8:  d = (a >= b) ? 1 : 0;
            9:  d = (a == b) ? 1 : 0;
            10: d = (a != b) ? 1 : 0;
            11: d = (a <= b) ? 1 : 0;
            12: d = (a <  b) ? 1 : 0;
            13: begin d = (a * b) % 256; c = (a * b) > 255; end
            14: begin
                d = (a * (1 << s)) % 256;
                c = (s == 0) ? 1'b0 : bit'((a >> (8 - s)) & 1);
            end
            default: wr = 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            check("busy_vs_ready", int'(busy), int'(!op_ready));
            if (acc_wr_en) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("wr_data", int'(acc_wr_data), mon_e.data);
                    check("cflag", int'(cflag), mon_e.c);
                    check("strobe_cycle", cyc, mon_e.due);
                end
            end
        end
    end

    // Presents one op and holds it until accepted; caller sits just after a posedge.
    task automatic issue(input int op, input int a, input int b, output int waited);
        bit rdy;
        bit wr;
        bit c;
        int d;
        op_valid = 1'b1;
        op_code  = 4'(op);
        op_a     = 8'(a);
        op_b     = 8'(b);
        waited   = 0;
        forever begin
            @(negedge clk);
            rdy = op_ready;
            @(posedge clk);
            if (rdy) break;
            waited++;
            if (waited > 40) begin
                check("accept_timeout", 1, 0);
                break;
            end
        end
        #1;
        model(op, a & 255, b & 255, model_c, wr, d, c);
        model_c = c;
        if (op == 13)
            sb.push_back('{data: d, c: int'(c), due: cyc + 9});
        else if (wr)
            sb.push_back('{data: d, c: int'(c), due: cyc});
    endtask

    task automatic idle(input int n);
        op_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_wr_en"}, int'(acc_wr_en), 0);
        check({tag, "_wr_data"}, int'(acc_wr_data), 0);
        check({tag, "_cflag"}, int'(cflag), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_op_ready"}, int'(op_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_reset_values("idle");

        issue(1, 8'hF0, 8'h20, w);
        issue(2, 8'h05, 8'h06, w);
        issue(3, 8'h3C, 8'h0F, w);
        issue(12, 8'h03, 8'h04, w);
        issue(6, 8'h55, 8'h00, w);
        idle(2);
        check("b2b_cflag_held", int'(cflag), 1);

        issue(13, 8'h12, 8'h10, w);
        issue(1, 8'h01, 8'h01, w);
        check("mul_stall_cycles", w, 9);
        idle(2);

        issue(14, 8'h81, 8'h01, w);
        issue(15, 8'h00, 8'h00, w);
        idle(3);
        check("nop_cflag", int'(cflag), 1);

        for (int i = 0; i < 300; i++) begin
            issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), w);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(12);
        check("scoreboard_drained", sb.size(), 0);

        issue(13, 8'hA5, 8'h7E, w);
        op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        sb.delete();
        model_c = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check_reset_values("post_reset");

        issue(1, 8'hFF, 8'h02, w);
        idle(3);
        check("final_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
